cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Result-side arbiter sitting directly downstream of the execution-unit wrappers (rot, add, logical, mul, ...).
- Accepts ready-valid results from NUM_UNITS units and picks one per cycle, round-robin.
- Registers the winner into a single output slot that drives the common data bus (CDB).
- The CDB feeds the update_op_* inputs of every reservation station and the commit stage.

Parameters:
- NUM_UNITS, 4, number of execution-unit result ports (≥2).
- RS_ID_WIDTH, 5, reservation-station id width; must match the wrappers.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- unit_valid  in  [0:NUM_UNITS-1]  per-unit result valid
- unit_ready  out  [0:NUM_UNITS-1]  per-unit result accepted
- unit_rs_id  in  [0:NUM_UNITS-1][0:RS_ID_WIDTH-1]  producing RS id
- unit_reg_addr  in  [0:NUM_UNITS-1][0:4]  destination GPR
- unit_result  in  [0:NUM_UNITS-1][0:31]  result value
- unit_cr0_xer  in  [0:NUM_UNITS-1] cond_exception_t  CR0/XER side result
- cdb_valid  out  1  broadcast valid
- cdb_ready  in  1  commit stage accepts broadcast
- cdb_rs_id  out  RS_ID_WIDTH  broadcast RS id
- cdb_reg_addr  out  5  broadcast destination GPR
- cdb_value  out  32  broadcast value
- cdb_cr0_xer  out  cond_exception_t  broadcast CR0/XER
- cdb_src  out  $clog2(NUM_UNITS)  index of the granting unit, for debug/perf

Behaviour:
- Reset (async, rst=1):
  - cdb_valid=0; cdb_rs_id, cdb_reg_addr, cdb_value, cdb_cr0_xer and cdb_src all zero.
  - Round-robin pointer ptr=0.
  - unit_ready=0 while rst is asserted.
- Output slot:
  - One register stage.
  - load_en = !cdb_valid || cdb_ready.
- Grant (combinational):
  - When load_en=1, grant the first i with unit_valid[i]=1, scanning ptr, ptr+1, ..., wrapping modulo NUM_UNITS.
  - unit_ready = one-hot grant; all zero when load_en=0 or no unit is valid.
  - unit_ready depends on unit_valid. Units must not make valid depend on ready (no loop).
- Transfer at the clock edge when unit_valid[g] and unit_ready[g]:
  - Slot loads unit g's fields and sets cdb_valid=1.
  - cdb_src=g.
  - ptr=(g+1) mod NUM_UNITS.
- Drain without refill: cdb_valid && cdb_ready with no grant → cdb_valid=0. Data fields hold their last value.
- Stall: cdb_valid && !cdb_ready → slot, ptr and cdb_* hold; unit_ready=0.
- Latency and throughput:
  - 1 cycle from unit handshake to cdb_valid.
  - Back-to-back: 1 result per cycle when cdb_ready stays 1.
- ptr changes only on a grant; an idle cycle does not advance it.
- Fairness: with all units valid continuously and cdb_ready=1, grants rotate 0,1,...,N-1,0. No unit waits more than NUM_UNITS-1 grants.
- cdb_valid is a single-cycle broadcast per accepted result.
  - RS snoop logic must treat each cdb_valid && cdb_ready cycle as exactly one update.
  - During a stall the same entry is visible for several cycles but is counted once.
- Reset mid-operation: an in-flight slot is discarded. Units keep their own results, since unit_ready went low.
- Width rules:
  - No arithmetic on data.
  - ptr width $clog2(NUM_UNITS). Wrap is explicit compare-to-(NUM_UNITS-1), so non-power-of-two counts are correct.

Decomposition:
- ppc_types gains cdb_t (packed: rs_id [0:4], reg_addr [0:4], value [0:31], cr0_xer cond_exception_t), used once RS_ID_WIDTH is fixed at 5.
- Inside the block, a local packed struct carries the parametric-width fields.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req, advance, clk, rst.
  - Outputs: one-hot grant and the index.
  - Owns ptr.
  - Reusable later for issue arbitration.

Test Plan:
- Reset check: rst=1 with unit_valid=4'b1111 → unit_ready=0 and cdb_valid=0. Deassert rst → first grant goes to unit 0.
- Single source: unit 2 valid (rs_id=5'h07, reg_addr=5'd3, value=32'hDEADBEEF), cdb_ready=1 → unit_ready=4'b0010 that cycle. Next cycle: cdb_valid=1, cdb_value=32'hDEADBEEF, cdb_rs_id=7, cdb_reg_addr=3, cdb_src=2.
- Round-robin: all four valid continuously for 8 cycles, cdb_ready=1 → cdb_src sequence 0,1,2,3,0,1,2,3, with one result every cycle.
- Backpressure: slot full, cdb_ready=0 for 3 cycles with units 1 and 3 valid → unit_ready=0 and cdb_* stable for those 3 cycles. Raise cdb_ready → the next grant follows ptr order.
- Pointer hold: grant to unit 1, then 2 idle cycles, then units 0 and 2 valid → unit 2 wins (ptr=2), then unit 0.
- Async reset mid-stall: cdb_valid=1, cdb_ready=0, rst pulses between clock edges → cdb_valid falls immediately without waiting for a clock edge, and ptr=0 afterwards.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the CDB result arbiter: condition/exception side result,
// the fixed-width CDB record and the round-robin wrap helper.
package cdb_arbiter_pkg;

    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
        logic so;
        logic ov;
        logic ca;
    } cond_exception_t;

    typedef struct packed {
        logic [0:4]      rs_id;
        logic [0:4]      reg_addr;
        logic [0:31]     value;
        cond_exception_t cr0_xer;
    } cdb_t;

    // Explicit compare keeps non-power-of-two unit counts correct.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-side bundle: per-unit ready/valid results in, one broadcast CDB slot out.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_UNITS   = 4,
    parameter int RS_ID_WIDTH = 5
);
    localparam int IW = $clog2(NUM_UNITS);

    logic [0:NUM_UNITS-1]                   unit_valid;
    logic [0:NUM_UNITS-1]                   unit_ready;
    logic [0:NUM_UNITS-1][0:RS_ID_WIDTH-1]  unit_rs_id;
    logic [0:NUM_UNITS-1][0:4]              unit_reg_addr;
    logic [0:NUM_UNITS-1][0:31]             unit_result;
    cond_exception_t [0:NUM_UNITS-1]        unit_cr0_xer;

    logic                   cdb_valid;
    logic                   cdb_ready;
    logic [0:RS_ID_WIDTH-1] cdb_rs_id;
    logic [0:4]             cdb_reg_addr;
    logic [0:31]            cdb_value;
    cond_exception_t        cdb_cr0_xer;
    logic [IW-1:0]          cdb_src;

    modport master (
        input  unit_valid, unit_rs_id, unit_reg_addr, unit_result, unit_cr0_xer, cdb_ready,
        output unit_ready, cdb_valid, cdb_rs_id, cdb_reg_addr, cdb_value, cdb_cr0_xer, cdb_src
    );

    modport slave (
        output unit_valid, unit_rs_id, unit_reg_addr, unit_result, unit_cr0_xer, cdb_ready,
        input  unit_ready, cdb_valid, cdb_rs_id, cdb_reg_addr, cdb_value, cdb_cr0_xer, cdb_src
    );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Generic round-robin arbiter: scans from ptr, grants the first requester and
// moves ptr just past the winner only when a grant is taken.
module rr_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [0:N-1]  i_req,
    input  logic          i_advance,
    output logic [0:N-1]  o_grant,
    output logic [IW-1:0] o_grant_idx,
    output logic          o_grant_vld
);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_scan_idx;
    logic [0:N-1]  w_grant;
    logic [IW-1:0] w_idx;
    logic          w_vld;

    always_comb begin
        w_grant    = '0;
        w_idx      = '0;
        w_vld      = 1'b0;
        w_scan_idx = '0;
        for (int k = 0; k < N; k++) begin
            w_scan_idx = IW'(rr_wrap(int'(r_ptr) + k, N));
            if (!w_vld && i_req[w_scan_idx]) begin
                w_vld               = 1'b1;
                w_idx               = w_scan_idx;
                w_grant[w_scan_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance && w_vld) begin
            r_ptr <= (w_idx == IW'(N - 1)) ? '0 : w_idx + IW'(1);
        end
    end

    assign o_grant     = w_grant;
    assign o_grant_idx = w_idx;
    assign o_grant_vld = w_vld;

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin pick among execution-unit results into a single
// registered broadcast slot that drives every reservation station and commit.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_UNITS   = 4,
    parameter int RS_ID_WIDTH = 5
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.master bus
);

    localparam int IW = $clog2(NUM_UNITS);

    typedef struct packed {
        logic [0:RS_ID_WIDTH-1] rs_id;
        logic [0:4]             reg_addr;
        logic [0:31]            value;
        cond_exception_t        cr0_xer;
    } slot_t;

    logic                 r_vld_p1;
    slot_t                r_slot_p1;
    logic [IW-1:0]        r_src_p1;

    logic                 w_load_en;
    logic [0:NUM_UNITS-1] w_req;
    logic [0:NUM_UNITS-1] w_grant;
    logic [IW-1:0]        w_gidx;
    logic                 w_gvld;
    slot_t                w_sel;

    // Slot may refill when empty or when its current entry is being consumed.
    assign w_load_en = !r_vld_p1 || bus.cdb_ready;
    assign w_req     = bus.unit_valid & {NUM_UNITS{w_load_en}};

    rr_arbiter #(.N(NUM_UNITS)) u_rr (
        .clk         (clk),
        .rst         (rst),
        .i_req       (w_req),
        .i_advance   (w_load_en),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx),
        .o_grant_vld (w_gvld)
    );

    assign bus.unit_ready = rst ? '0 : w_grant;

    always_comb begin
        w_sel          = '0;
        w_sel.rs_id    = bus.unit_rs_id[w_gidx];
        w_sel.reg_addr = bus.unit_reg_addr[w_gidx];
        w_sel.value    = bus.unit_result[w_gidx];
        w_sel.cr0_xer  = bus.unit_cr0_xer[w_gidx];
    end

    // p1: broadcast slot; data holds on drain, only valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_slot_p1 <= '0;
            r_src_p1  <= '0;
        end else if (w_load_en) begin
            r_vld_p1 <= w_gvld;
            if (w_gvld) begin
                r_slot_p1 <= w_sel;
                r_src_p1  <= w_gidx;
            end
        end
    end

    assign bus.cdb_valid    = r_vld_p1;
    assign bus.cdb_rs_id    = r_slot_p1.rs_id;
    assign bus.cdb_reg_addr = r_slot_p1.reg_addr;
    assign bus.cdb_value    = r_slot_p1.value;
    assign bus.cdb_cr0_xer  = r_slot_p1.cr0_xer;
    assign bus.cdb_src      = r_src_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected broadcasts are queued at grant time
// and popped when the CDB entry is consumed.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clk;
    logic rst;

    cdb_arbiter_if #(.NUM_UNITS(4), .RS_ID_WIDTH(5)) bus ();

    cdb_arbiter #(.NUM_UNITS(4), .RS_ID_WIDTH(5)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic [1:0]  src;
        logic [4:0]  rs;
        logic [4:0]  ra;
        logic [31:0] val;
        logic [5:0]  cr;
    } exp_t;

    exp_t        sb[$];
    logic [4:0]  td_rs [4];
    logic [4:0]  td_ra [4];
    logic [31:0] td_val[4];
    logic [5:0]  td_cr [4];
    int          n_cmp  = 0;
    int          n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_unit(input logic [1:0] u, input logic [4:0] rs, input logic [4:0] ra,
                            input logic [31:0] val, input logic [5:0] cr);
        td_rs[u]  = rs;
        td_ra[u]  = ra;
        td_val[u] = val;
        td_cr[u]  = cr;
        bus.unit_rs_id[u]    = rs;
        bus.unit_reg_addr[u] = ra;
        bus.unit_result[u]   = val;
        bus.unit_cr0_xer[u]  = cond_exception_t'(cr);
    endtask

    task automatic expect_grant(input logic [1:0] u);
        logic [0:3] e;
        exp_t       x;
        e    = '0;
        e[u] = 1'b1;
        check($sformatf("ready_u%0d", u), 64'(bus.unit_ready), 64'(e));
        x.src = u;
        x.rs  = td_rs[u];
        x.ra  = td_ra[u];
        x.val = td_val[u];
        x.cr  = td_cr[u];
        sb.push_back(x);
    endtask

    task automatic expect_no_grant(input string tag);
        check(tag, 64'(bus.unit_ready), 64'd0);
    endtask

    task automatic observe();
        exp_t x;
        if (bus.cdb_valid && bus.cdb_ready) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_pop: observed empty queue expected a pending entry");
            end
            if (sb.size() != 0) begin
                x = sb.pop_front();
                check("cdb_src",      64'(bus.cdb_src),      64'(x.src));
                check("cdb_rs_id",    64'(bus.cdb_rs_id),    64'(x.rs));
                check("cdb_reg_addr", 64'(bus.cdb_reg_addr), 64'(x.ra));
                check("cdb_value",    64'(bus.cdb_value),    64'(x.val));
                check("cdb_cr0_xer",  64'(bus.cdb_cr0_xer),  64'(x.cr));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        bus.cdb_ready  = 1'b1;
        bus.unit_valid = 4'b1111;
        for (int u = 0; u < 4; u++) begin
            set_unit(2'(u), 5'(u * 3 + 1), 5'(u + 10), 32'hA5A5_0000 + 32'(u * 17), 6'(u * 5 + 2));
        end

        // Reset state and no grants while rst is high.
        #2;
        check("rst_ready",     64'(bus.unit_ready), 64'd0);
        check("rst_cdb_valid", 64'(bus.cdb_valid),  64'd0);
        check("rst_cdb_value", 64'(bus.cdb_value),  64'd0);
        check("rst_cdb_src",   64'(bus.cdb_src),    64'd0);
        tick();
        tick();
        check("rst_ready_held", 64'(bus.unit_ready), 64'd0);
        rst = 1'b0;
        #1;

        // Round robin with all four valid: 0,1,2,3,0,1,2,3, one per cycle.
        expect_grant(2'd0);
        observe();
        tick();
        for (int k = 1; k < 8; k++) begin
            check("rr_valid", 64'(bus.cdb_valid), 64'd1);
            expect_grant(2'(k % 4));
            observe();
            tick();
        end
        bus.unit_valid = 4'b0000;
        #1;
        expect_no_grant("drain_ready");
        observe();
        tick();
        check("drain_valid",    64'(bus.cdb_valid), 64'd0);
        check("drain_hold_src", 64'(bus.cdb_src),   64'd3);
        check("drain_hold_val", 64'(bus.cdb_value), 64'(td_val[3]));

        // Single source, unit 2.
        set_unit(2'd2, 5'h07, 5'd3, 32'hDEADBEEF, 6'h15);
        bus.unit_valid = 4'b0010;
        #1;
        expect_grant(2'd2);
        observe();
        tick();
        bus.unit_valid = 4'b0000;
        #1;
        check("single_valid", 64'(bus.cdb_valid),    64'd1);
        check("single_src",   64'(bus.cdb_src),      64'd2);
        check("single_value", 64'(bus.cdb_value),    64'hDEADBEEF);
        check("single_rs",    64'(bus.cdb_rs_id),    64'h07);
        check("single_ra",    64'(bus.cdb_reg_addr), 64'd3);
        observe();
        expect_no_grant("single_idle_ready");
        tick();

        // Backpressure: ptr=3, units 1 and 3 valid.
        bus.unit_valid = 4'b0101;
        #1;
        expect_grant(2'd3);
        observe();
        tick();
        bus.cdb_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            expect_no_grant("stall_ready");
            check("stall_valid", 64'(bus.cdb_valid), 64'd1);
            check("stall_src",   64'(bus.cdb_src),   64'd3);
            check("stall_value", 64'(bus.cdb_value), 64'(td_val[3]));
            observe();
            tick();
        end
        bus.cdb_ready = 1'b1;
        #1;
        expect_grant(2'd1);
        observe();
        tick();

        // Pointer hold across idle cycles, then units 0 and 2.
        bus.unit_valid = 4'b0000;
        #1;
        expect_no_grant("idle1_ready");
        observe();
        tick();
        #1;
        expect_no_grant("idle2_ready");
        check("idle2_valid", 64'(bus.cdb_valid), 64'd0);
        observe();
        tick();
        bus.unit_valid = 4'b1010;
        #1;
        expect_grant(2'd2);
        observe();
        tick();
        #1;
        expect_grant(2'd0);
        observe();
        tick();
        bus.unit_valid = 4'b0000;
        #1;
        observe();
        tick();

        // Async reset while the slot is stalled.
        bus.unit_valid = 4'b0100;
        #1;
        expect_grant(2'd1);
        tick();
        bus.cdb_ready  = 1'b0;
        bus.unit_valid = 4'b1111;
        #1;
        check("pre_rst_valid", 64'(bus.cdb_valid), 64'd1);
        expect_no_grant("pre_rst_ready");
        rst = 1'b1;
        #1;
        check("async_valid", 64'(bus.cdb_valid),  64'd0);
        check("async_src",   64'(bus.cdb_src),    64'd0);
        check("async_value", 64'(bus.cdb_value),  64'd0);
        check("async_ready", 64'(bus.unit_ready), 64'd0);
        sb.delete();
        #2;
        rst            = 1'b0;
        bus.unit_valid = 4'b0110;
        bus.cdb_ready  = 1'b1;
        #1;
        expect_grant(2'd1);
        tick();
        bus.unit_valid = 4'b0000;
        #1;
        observe();
        tick();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
